// File: rtl/bps_column_ctrl_pkg.sv
// Shared types for the B/PS column edge controller.
package bps_column_ctrl_pkg;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [15:0] int16_t;

  // IDLE    | waiting for start_i
  // FILL    | accepting ROWS weight beats into the staging registers
  // LOAD    | ROWS-cycle load_B burst, bottom row weight first
  // COMPUTE | zero partial sums at the top, capturing finished sums at the bottom
  // DRAIN   | no new vectors, waiting for in-flight sums to reach the bottom
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    LOAD    = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } bps_col_state_e;

  // Weights travel on the shared wire zero-extended; the PE reinterprets the low byte.
  function automatic logic [15:0] b_to_bps(input int8_t b);
    return {8'h00, b};
  endfunction

endpackage

// File: rtl/bps_result_fifo.sv
// Result FIFO for finished column sums. Push and pop in the same cycle are
// legal even when full; the caller decides what to do with a rejected push.
module bps_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/bps_column_ctrl.sv
// Top/bottom edge controller for one systolic column with shared B/PS wires.
// Stages a column of weights, bursts them with load_B (bottom row first),
// then feeds zero partial sums and captures the finished sums ROWS cycles
// after each vector's col_valid_i. Assumes ROWS >= 2.
module bps_column_ctrl
  import bps_column_ctrl_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        start_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  logic [7:0]  b_data_i,
  output logic        load_B_o,
  output logic [15:0] bps_top_o,
  input  logic [15:0] bps_bot_i,
  input  logic        col_valid_i,
  input  logic        done_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_data_o,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROWS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  bps_col_state_e  state_q;
  logic [CW-1:0]   fill_cnt_q;
  logic [CW-1:0]   ld_cnt_q;
  int8_t           stage_q [ROWS];
  logic            b_ready_q;
  logic            load_q;
  logic [15:0]     bps_top_q;
  logic [ROWS-1:0] dl_q;
  logic [ROWS-1:0] dl_d;
  logic            overflow_q;

  logic            col_in;
  logic            cap_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;

  // Only vectors issued during COMPUTE are tracked; load-phase bottom values never qualify.
  assign col_in   = (state_q == COMPUTE) && col_valid_i;
  assign dl_d     = {dl_q[ROWS-2:0], col_in};
  assign cap_push = dl_q[ROWS-1];
  assign fifo_pop = res_ready_i && !fifo_empty;

  // Control FSM with registered b_ready/load_B/bps_top; ld_cnt_q counts down the stage index being sent.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      ld_cnt_q   <= '0;
      b_ready_q  <= 1'b0;
      load_q     <= 1'b0;
      bps_top_q  <= '0;
      for (int i = 0; i < ROWS; i++) stage_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= FILL;
            b_ready_q  <= 1'b1;
            fill_cnt_q <= '0;
          end
        end
        FILL: begin
          if (b_valid_i && b_ready_q) begin
            stage_q[fill_cnt_q] <= b_data_i;
            if (fill_cnt_q == CNT_LAST) begin
              // Last beat goes straight onto the wire as burst cycle 0.
              state_q   <= LOAD;
              b_ready_q <= 1'b0;
              load_q    <= 1'b1;
              bps_top_q <= b_to_bps(b_data_i);
              ld_cnt_q  <= CNT_LAST;
            end else begin
              fill_cnt_q <= fill_cnt_q + CNT_ONE;
            end
          end
        end
        LOAD: begin
          if (ld_cnt_q == '0) begin
            state_q   <= COMPUTE;
            load_q    <= 1'b0;
            bps_top_q <= '0;
          end else begin
            ld_cnt_q  <= ld_cnt_q - CNT_ONE;
            bps_top_q <= b_to_bps(stage_q[ld_cnt_q - CNT_ONE]);
          end
        end
        COMPUTE: begin
          if (done_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (dl_d == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delay line aligning each vector's col_valid with its sum at the bottom.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) dl_q <= '0;
    else       dl_q <= dl_d;
  end

  // Sticky overflow: set on a dropped capture, cleared when a new job starts.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      overflow_q <= 1'b0;
    end else if (cap_push && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end
  end

  bps_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset       (reset),
    .push_i      (cap_push),
    .push_data_i (bps_bot_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (res_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign b_ready_o   = b_ready_q;
  assign load_B_o    = load_q;
  assign bps_top_o   = bps_top_q;
  assign res_valid_o = !fifo_empty;
  assign busy_o      = (state_q != IDLE);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_bps_column_ctrl.sv
// Scoreboard bench for bps_column_ctrl with a behavioural 4-PE column.
module tb_bps_column_ctrl;

  localparam int ROWS  = 4;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic        b_valid_i = 1'b0;
  logic        b_ready_o;
  logic [7:0]  b_data_i = '0;
  logic        load_B_o;
  logic [15:0] bps_top_o;
  logic [15:0] bps_bot_i = '0;
  logic        col_valid_i = 1'b0;
  logic        done_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [15:0] res_data_o;
  logic        busy_o;
  logic        overflow_o;

  always #5 clk_i = ~clk_i;

  bps_column_ctrl #(.ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .start_i     (start_i),
    .b_valid_i   (b_valid_i),
    .b_ready_o   (b_ready_o),
    .b_data_i    (b_data_i),
    .load_B_o    (load_B_o),
    .bps_top_o   (bps_top_o),
    .bps_bot_i   (bps_bot_i),
    .col_valid_i (col_valid_i),
    .done_i      (done_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 1;      // 0: never ready, 1: always ready, 2: random
  int n_pops   = 0;

  logic [15:0] bot_sched [int];   // value the column presents at the bottom, by cycle
  logic [15:0] exp_sched [int];   // expected capture, by cycle
  logic [15:0] exp_q [$];         // modelled FIFO contents
  bit          model_ovf = 1'b0;

  int pe_w [ROWS];                // weights actually held by the column model
  int wts  [ROWS];                // weights the bench sends
  int avec [ROWS];
  int fixv [2][ROWS] = '{'{1, 1, 1, 1}, '{2, 0, -1, 5}};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    bps_bot_i = bot_sched.exists(cyc) ? bot_sched[cyc] : 16'($urandom);
    case (rdy_mode)
      0:       res_ready_i = 1'b0;
      1:       res_ready_i = 1'b1;
      default: res_ready_i = 1'($urandom);
    endcase
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Monitor / reference model, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!reset) begin
      chk("res_valid", {31'b0, res_valid_o}, {31'b0, exp_q.size() != 0});
      chk("overflow", {31'b0, overflow_o}, {31'b0, model_ovf});
      if (exp_q.size() != 0 && res_ready_i) begin
        chk("res_data", {16'b0, res_data_o}, {16'b0, exp_q.pop_front()});
        n_pops++;
      end
      if (exp_sched.exists(cyc)) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(exp_sched[cyc]);
        else                      model_ovf = 1'b1;
        exp_sched.delete(cyc);
      end
      if (start_i && !busy_o) model_ovf = 1'b0;
      if (load_B_o) begin
        for (int r = ROWS - 1; r > 0; r--) pe_w[r] = pe_w[r-1];
        pe_w[0] = int'($signed(bps_top_o[7:0]));
      end
    end
  end

  task automatic issue_vec();
    int e = 0;
    int p = 0;
    for (int r = 0; r < ROWS; r++) begin
      e += avec[r] * wts[r];
      p += avec[r] * pe_w[r];
    end
    col_valid_i = 1'b1;
    bot_sched[cyc + ROWS] = 16'(p);
    exp_sched[cyc + ROWS] = 16'(e);
  endtask

  task automatic do_load(input bit gaps, input int abort_at);
    start_i     = 1'b1;
    col_valid_i = 1'($urandom);
    tick();
    start_i = 1'b0;
    chk("fill_ready", {31'b0, b_ready_o}, 32'd1);
    chk("fill_busy", {31'b0, busy_o}, 32'd1);
    chk("ovf_clr", {31'b0, overflow_o}, 32'd0);
    for (int k = 0; k < ROWS; k++) begin
      if (gaps) begin
        b_valid_i   = 1'b0;
        col_valid_i = 1'($urandom);
        tick();
        chk("gap_ready", {31'b0, b_ready_o}, 32'd1);
        chk("gap_noload", {31'b0, load_B_o}, 32'd0);
      end
      b_valid_i   = 1'b1;
      b_data_i    = 8'(wts[k]);
      col_valid_i = 1'($urandom);
      tick();
    end
    b_valid_i = 1'b0;
    for (int j = 0; j < ROWS; j++) begin
      if (j == abort_at) return;
      chk("load_hi", {31'b0, load_B_o}, 32'd1);
      chk("load_ready", {31'b0, b_ready_o}, 32'd0);
      chk("load_top", {16'b0, bps_top_o}, {16'b0, 16'(wts[ROWS-1-j] & 255)});
      col_valid_i = 1'($urandom);
      tick();
    end
    col_valid_i = 1'b0;
    chk("load_end", {31'b0, load_B_o}, 32'd0);
    chk("top_zero", {16'b0, bps_top_o}, 32'd0);
    chk("comp_busy", {31'b0, busy_o}, 32'd1);
  endtask

  task automatic do_compute(input int nvec, input bit fixed_vecs);
    int last = -1000;
    int tdone = 0;
    int exp_len;
    for (int v = 0; v < nvec; v++) begin
      repeat ($urandom_range(0, 2)) tick();
      for (int r = 0; r < ROWS; r++) avec[r] = fixed_vecs ? fixv[v][r] : rnd8();
      issue_vec();
      last = cyc;
      if (v == nvec - 1 && $urandom_range(0, 1) == 1) begin
        done_i = 1'b1;
        tdone  = cyc;
      end
      tick();
      col_valid_i = 1'b0;
    end
    if (!done_i) begin
      repeat ($urandom_range(0, 3)) tick();
      done_i = 1'b1;
      tdone  = cyc;
      tick();
    end
    done_i = 1'b0;
    while (busy_o && (cyc - tdone) < 2 * ROWS + 4) begin
      col_valid_i = 1'($urandom);
      tick();
    end
    col_valid_i = 1'b0;
    chk("drain_idle", {31'b0, busy_o}, 32'd0);
    exp_len = (last + ROWS + 1 - tdone > 2) ? last + ROWS + 1 - tdone : 2;
    chk("drain_len", cyc - tdone, exp_len);
  endtask

  task automatic flush(input int mode);
    int n = 0;
    rdy_mode = mode;
    while ((exp_q.size() != 0 || res_valid_o) && n < 200) begin
      tick();
      n++;
    end
    chk("flush_empty", {31'b0, res_valid_o}, 32'd0);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_load", {31'b0, load_B_o}, 32'd0);
    chk("rst_ready", {31'b0, b_ready_o}, 32'd0);
    chk("rst_top", {16'b0, bps_top_o}, 32'd0);
    chk("rst_valid", {31'b0, res_valid_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ovf", {31'b0, overflow_o}, 32'd0);
    exp_q.delete();
    exp_sched.delete();
    bot_sched.delete();
    model_ovf   = 1'b0;
    start_i     = 1'b0;
    b_valid_i   = 1'b0;
    col_valid_i = 1'b0;
    done_i      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < ROWS; r++) pe_w[r] = 0;
    #2;
    chk("init_load", {31'b0, load_B_o}, 32'd0);
    chk("init_ready", {31'b0, b_ready_o}, 32'd0);
    chk("init_top", {16'b0, bps_top_o}, 32'd0);
    chk("init_valid", {31'b0, res_valid_o}, 32'd0);
    chk("init_busy", {31'b0, busy_o}, 32'd0);
    chk("init_ovf", {31'b0, overflow_o}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Weights 1..4 gapless, then the two reference vectors (10, 19).
    for (int r = 0; r < ROWS; r++) wts[r] = r + 1;
    rdy_mode = 1;
    do_load(1'b0, -1);
    do_compute(2, 1'b1);
    flush(1);

    // Reset while idle.
    apply_reset();

    // Same weights with alternating b_valid gaps.
    do_load(1'b1, -1);
    do_compute(3, 1'b0);
    flush(2);

    // Randomized jobs with random backpressure.
    for (int job = 0; job < 6; job++) begin
      for (int r = 0; r < ROWS; r++) wts[r] = rnd8();
      rdy_mode = int'($urandom_range(1, 2));
      do_load(1'($urandom), -1);
      do_compute(int'($urandom_range(1, 8)), 1'b0);
      flush(2);
    end

    // Overflow: consumer stalled, six vectors into a 4-deep FIFO.
    for (int r = 0; r < ROWS; r++) wts[r] = rnd8();
    rdy_mode = 0;
    do_load(1'b0, -1);
    n_pops = 0;
    do_compute(6, 1'b0);
    chk("ovf_set", {31'b0, overflow_o}, 32'd1);
    flush(1);
    chk("ovf_pops", n_pops, 4);
    rdy_mode = 1;
    do_load(1'b0, -1);
    do_compute(1, 1'b0);
    flush(1);

    // Leave stale results, abort the next job mid-LOAD, then rerun the reference job.
    for (int r = 0; r < ROWS; r++) wts[r] = rnd8();
    rdy_mode = 0;
    do_load(1'b0, -1);
    do_compute(2, 1'b0);
    do_load(1'b0, 1);
    apply_reset();
    for (int r = 0; r < ROWS; r++) wts[r] = r + 1;
    rdy_mode = 1;
    do_load(1'b0, -1);
    do_compute(2, 1'b1);
    flush(1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bps_column_ctrl.md
Name: bps_column_ctrl

Overview:
Edge controller for one systolic-array column built from PEs whose B-weight and partial-sum wires are shared. It acts as the transmitter at the top of the column and the receiver at the bottom. At the top it stages a column of B weights, bursts them gaplessly with load_B, then drives zero partial sums. At the bottom it captures the finished 16-bit partial sums, aligned to the A-vector schedule, into a result FIFO with valid/ready handshake.

Parameters:
ROWS, 4, number of PEs in the column (load burst length and result latency)
FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2)

Ports:
clk_i  input  1  clock
reset  input  1  asynchronous, active-high reset
start_i  input  1  pulse in IDLE: begin a new job (enter FILL), clear overflow_o
b_valid_i  input  1  weight beat valid
b_ready_o  output  1  weight beat accepted when valid&ready
b_data_i  input  8  int8_t weight; beat k is the weight for row k (row 0 = top)
load_B_o  output  1  broadcast load_B to all PEs of the column
bps_top_o  output  16  shared B/PS into row-0 PE
bps_bot_i  input  16  shared B/PS out of row ROWS-1 PE
col_valid_i  input  1  cycle in which a vector's row-0 A element enters row 0 of this column
done_i  input  1  last A vector has been issued (COMPUTE only)
res_valid_o  output  1  result available
res_ready_i  input  1  consumer accepts result
res_data_o  output  16  int16_t column dot product
busy_o  output  1  state != IDLE
overflow_o  output  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (async): state IDLE. All outputs 0, including b_ready_o, load_B_o, bps_top_o, res_valid_o and overflow_o. FIFO, staging and delay line are cleared. A reset during any state aborts the job immediately; load_B_o falls without waiting for a clock.
- IDLE: b_ready_o=0, load_B_o=0, bps_top_o=0. start_i moves to FILL. start_i is ignored in all other states.
- FILL: b_ready_o=1. Each accepted beat writes stage[k], with k counting 0..ROWS-1. Gaps in b_valid_i are allowed. The cycle after the ROWS-th accept, enter LOAD; b_ready_o is 0 in that cycle.
- LOAD: exactly ROWS consecutive cycles, never interrupted. load_B_o=1 and bps_top_o={8'b0, stage[ROWS-1-j]} on burst cycle j. The bottom weight goes out first so each row ends holding its own weight. The next cycle enters COMPUTE.
- COMPUTE: load_B_o=0, bps_top_o=16'h0000.
  - col_valid_i enters a ROWS-deep delay line.
  - When the delay-line output is 1, bps_bot_i is pushed into the FIFO in that cycle. Latency from col_valid_i to capture is exactly ROWS cycles.
  - done_i moves to DRAIN. A col_valid_i in the same cycle as done_i is still counted.
- DRAIN: same outputs as COMPUTE. col_valid_i is ignored and the delay line keeps shifting. When the delay line is all zero, return to IDLE (at most ROWS cycles).
- col_valid_i is ignored in IDLE, FILL and LOAD, so load-phase bottom values ({0,B}) are never captured.
- Arithmetic: no computation here. Results are 16-bit two's complement and pass through exactly as the PEs produced them (wraparound already applied).
- FIFO:
  - res_data_o is valid whenever res_valid_o=1 and holds stable until accepted.
  - Push and pop in the same cycle are legal in every state, including when full.
  - Push when full without a pop: the value is dropped and overflow_o=1. overflow_o is sticky until reset or start_i.
  - The FIFO persists across jobs, so a new start_i may come while results are still draining.

Decomposition:
- PE_pkg: reuse int8_t/int16_t; add bps_col_state_e {IDLE, FILL, LOAD, COMPUTE, DRAIN}.
- Sub-module bps_result_fifo: synchronous FIFO, parameter DEPTH/WIDTH=16, with push/pop/full/empty; same clock and asynchronous reset.
- FSM, staging, load counter and delay line stay in the top module.

Test Plan:
1. Reset while idle and mid-operation -> all outputs 0 immediately; busy_o=0; res_valid_o=0.
2. ROWS=4: start_i, then weights 1,2,3,4 with no gaps -> b_ready_o drops after 4 accepts; load_B_o high exactly 4 cycles; bps_top_o = 0x0004, 0x0003, 0x0002, 0x0001, then 0x0000.
3. Same weights with b_valid_i toggling every other cycle -> LOAD burst still 4 contiguous cycles, starting the cycle after the 4th accept.
4. With a 4-PE behavioural column and skewed A feed: B=[1,2,3,4], vectors A=[1,1,1,1] and A=[2,0,-1,5], then done_i -> FIFO outputs 10 then 19, each captured 4 cycles after its col_valid_i; return to IDLE within 4 cycles of done_i.
5. FIFO_DEPTH=4, res_ready_i=0, 6 vectors -> 4 results held in order; overflow_o=1 after the 5th; after releasing res_ready_i, exactly 4 pops; next start_i clears overflow_o.
6. Assert reset during cycle 2 of LOAD, release, then run scenario 4 -> load_B_o falls asynchronously; the new job produces 10 and 19 with no stale entries.
